// File: rtl/opacc_pkg.sv
// Shared types for the outer-product accumulator and its drain stage.
// Row/entry types are sized for the default accumulator shape; parameterized blocks size their own.
package opacc_pkg;

  localparam int unsigned OPACC_XLEN = 64;
  localparam int unsigned OPACC_VL   = 2;
  localparam int unsigned OPACC_ML   = 2;

  // Index width that never collapses to zero bits for a single-row accumulator.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef logic [OPACC_VL-1:0][OPACC_XLEN-1:0] row_t;

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    FLUSH
  } drain_state_e;

  typedef struct packed {
    row_t                          data;
    logic [idx_w(OPACC_ML)-1:0]    row;
    logic                          last;
  } fifo_entry_t;

endpackage

// File: rtl/opacc_row_fifo.sv
// Synchronous first-word-fall-through FIFO with wrap-around pointers and an occupancy counter.
module opacc_row_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] rdata
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/opacc_drain.sv
// Drains all accumulator rows through a small FIFO onto a valid/ready stream,
// shifting zeros back in so the accumulator ends up cleared.
module opacc_drain
  import opacc_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int vl    = 2,
  parameter int ml    = 2,
  parameter int DEPTH = ml
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    drain_start,
  output logic                    busy,
  output logic                    done,
  output logic                    en_c,
  output logic [vl*XLEN-1:0]      vo_c_acc,
  input  logic [vl*XLEN-1:0]      vi_row,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [vl*XLEN-1:0]      out_data,
  output logic [idx_w(ml)-1:0]    out_row,
  output logic                    out_last
);

  localparam int RW = idx_w(ml);
  localparam int CW = $clog2(ml + 1);

  typedef struct packed {
    logic [vl*XLEN-1:0] data;
    logic [RW-1:0]      row;
    logic               last;
  } slot_t;

  drain_state_e  state;
  logic [CW-1:0] shift_cnt;
  logic          last_shift;
  logic          fifo_full;
  logic          fifo_empty;
  logic          pop;
  slot_t         wslot;
  slot_t         rslot;

  assign last_shift = (shift_cnt == CW'(ml - 1));
  assign en_c       = (state == DRAIN) && !fifo_full;
  assign pop        = !fifo_empty && out_ready;
  assign vo_c_acc   = '0;
  assign busy       = (state != IDLE);
  // Only the final row carries last, and it is always popped after the move to FLUSH.
  assign done       = (state == FLUSH) && pop && rslot.last;

  assign wslot.data = vi_row;
  assign wslot.row  = shift_cnt[RW-1:0];
  assign wslot.last = last_shift;

  opacc_row_fifo #(
    .W     ($bits(slot_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (en_c),
    .pop   (pop),
    .wdata (wslot),
    .full  (fifo_full),
    .empty (fifo_empty),
    .rdata (rslot)
  );

  // Stale storage is masked so the stream reads zero whenever nothing is queued.
  assign out_valid = !fifo_empty;
  assign out_data  = fifo_empty ? '0 : rslot.data;
  assign out_row   = fifo_empty ? '0 : rslot.row;
  assign out_last  = !fifo_empty && rslot.last;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      shift_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (drain_start) begin
            state     <= DRAIN;
            shift_cnt <= '0;
          end
        end
        DRAIN: begin
          if (en_c) begin
            shift_cnt <= shift_cnt + 1'b1;
            if (last_shift) state <= FLUSH;
          end
        end
        FLUSH: begin
          if (done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_opacc_drain.sv
// Directed bench for opacc_drain: default shape (ml=2) plus a DEPTH=1, ml=4 instance,
// each fed by a small shift-register model of the accumulator.
module tb_opacc_drain;

  localparam int RB = 128;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  int   n_chk  = 0;
  int   n_fail = 0;

  // instance A: ml=2, DEPTH=2
  logic          ds_a, busy_a, done_a, en_a, ov_a, or_a, last_a;
  logic [RB-1:0] acc_in_a, vi_a, od_a;
  logic [0:0]    row_a;
  logic [RB-1:0] acc_a [2];
  logic [RB-1:0] ld_a [2];
  logic          ld_go_a;

  // instance B: ml=4, DEPTH=1
  logic          ds_b, busy_b, done_b, en_b, ov_b, or_b, last_b;
  logic [RB-1:0] acc_in_b, vi_b, od_b;
  logic [1:0]    row_b;
  logic [RB-1:0] acc_b [4];
  logic [RB-1:0] ld_b [4];
  logic          ld_go_b;

  opacc_drain #(.XLEN(64), .vl(2), .ml(2), .DEPTH(2)) dut_a (
    .clk(clk), .reset(reset), .drain_start(ds_a), .busy(busy_a), .done(done_a),
    .en_c(en_a), .vo_c_acc(acc_in_a), .vi_row(vi_a), .out_valid(ov_a),
    .out_ready(or_a), .out_data(od_a), .out_row(row_a), .out_last(last_a)
  );

  opacc_drain #(.XLEN(64), .vl(2), .ml(4), .DEPTH(1)) dut_b (
    .clk(clk), .reset(reset), .drain_start(ds_b), .busy(busy_b), .done(done_b),
    .en_c(en_b), .vo_c_acc(acc_in_b), .vi_row(vi_b), .out_valid(ov_b),
    .out_ready(or_b), .out_data(od_b), .out_row(row_b), .out_last(last_b)
  );

  // Accumulator models: row 0 is presented, each en_c shifts up and inserts vo_c_acc at the top.
  assign vi_a = acc_a[0];
  assign vi_b = acc_b[0];

  always @(posedge clk) begin
    if (ld_go_a) begin
      acc_a[0] <= ld_a[0];
      acc_a[1] <= ld_a[1];
    end else if (en_a) begin
      acc_a[0] <= acc_a[1];
      acc_a[1] <= acc_in_a;
    end
  end

  always @(posedge clk) begin
    if (ld_go_b) begin
      for (int k = 0; k < 4; k++) acc_b[k] <= ld_b[k];
    end else if (en_b) begin
      for (int k = 0; k < 3; k++) acc_b[k] <= acc_b[k+1];
      acc_b[3] <= acc_in_b;
    end
  end

  function automatic logic [RB-1:0] mkrow(input logic [63:0] e0, input logic [63:0] e1);
    return {e1, e0};
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [RB-1:0] obs, input logic [RB-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chkn(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic load_a(input logic [RB-1:0] r0, input logic [RB-1:0] r1);
    ld_a[0] = r0;
    ld_a[1] = r1;
    ld_go_a = 1'b1;
    step;
    ld_go_a = 1'b0;
  endtask

  // Unstalled drain of instance A: en_c at t+1,t+2; rows out at t+2,t+3; done at t+3.
  task automatic drain_fast_a(input string tag, input logic [RB-1:0] r0, input logic [RB-1:0] r1);
    ds_a = 1'b1;
    step;
    ds_a = 1'b0;
    chk1({tag, "_busy_t1"}, busy_a, 1'b1);
    chk1({tag, "_en_t1"}, en_a, 1'b1);
    chk1({tag, "_valid_t1"}, ov_a, 1'b0);
    chkw({tag, "_acc_in"}, acc_in_a, '0);
    step;
    chk1({tag, "_en_t2"}, en_a, 1'b1);
    chk1({tag, "_valid_t2"}, ov_a, 1'b1);
    chkw({tag, "_data_row0"}, od_a, r0);
    chk1({tag, "_row0_idx"}, row_a[0], 1'b0);
    chk1({tag, "_row0_last"}, last_a, 1'b0);
    chk1({tag, "_done_t2"}, done_a, 1'b0);
    step;
    chk1({tag, "_en_t3"}, en_a, 1'b0);
    chkw({tag, "_data_row1"}, od_a, r1);
    chk1({tag, "_row1_idx"}, row_a[0], 1'b1);
    chk1({tag, "_row1_last"}, last_a, 1'b1);
    chk1({tag, "_done_t3"}, done_a, 1'b1);
    step;
    chk1({tag, "_busy_end"}, busy_a, 1'b0);
    chk1({tag, "_valid_end"}, ov_a, 1'b0);
    chk1({tag, "_done_end"}, done_a, 1'b0);
    chkw({tag, "_acc_cleared"}, acc_a[0] | acc_a[1], '0);
  endtask

  initial begin
    int en_cnt, pops, dones;
    logic [RB-1:0] exp_rows [4];

    reset = 1'b1;
    ds_a = 1'b0; or_a = 1'b0; ld_go_a = 1'b0; ld_a[0] = '0; ld_a[1] = '0;
    ds_b = 1'b0; or_b = 1'b0; ld_go_b = 1'b0;
    for (int k = 0; k < 4; k++) ld_b[k] = '0;
    step;
    step;

    // Reset state
    chk1("rst_busy", busy_a, 1'b0);
    chk1("rst_done", done_a, 1'b0);
    chk1("rst_en", en_a, 1'b0);
    chk1("rst_valid", ov_a, 1'b0);
    chkw("rst_data", od_a, '0);
    chk1("rst_row", row_a[0], 1'b0);
    chk1("rst_last", last_a, 1'b0);
    chk1("rst_b_busy", busy_b, 1'b0);
    chk1("rst_b_valid", ov_b, 1'b0);
    reset = 1'b0;
    step;

    // Basic drain
    load_a(mkrow(64'h0, 64'h0), mkrow(64'h0, 64'h1));
    or_a = 1'b1;
    drain_fast_a("basic", mkrow(64'h0, 64'h0), mkrow(64'h0, 64'h1));
    load_a(mkrow(64'hA5A5_0000_1111_2222, 64'h3), mkrow(64'h7, 64'hDEAD_BEEF_0000_0001));
    drain_fast_a("basic2", mkrow(64'hA5A5_0000_1111_2222, 64'h3), mkrow(64'h7, 64'hDEAD_BEEF_0000_0001));

    // Backpressure: FIFO fills after two shifts and holds row 0 steady
    load_a(mkrow(64'h20, 64'h21), mkrow(64'h30, 64'h31));
    or_a = 1'b0;
    ds_a = 1'b1;
    step;
    ds_a = 1'b0;
    en_cnt = 0;
    for (int i = 1; i <= 6; i++) begin
      if (en_a) en_cnt++;
      if (i >= 2) chkw("bp_hold_data", od_a, mkrow(64'h20, 64'h21));
      if (i < 6) step;
    end
    chkn("bp_en_pulses", en_cnt, 2);
    chk1("bp_en_held_low", en_a, 1'b0);
    chk1("bp_done_stalled", done_a, 1'b0);
    or_a = 1'b1;
    #1;
    chk1("bp_done_first_pop", done_a, 1'b0);
    step;
    chkw("bp_row1_data", od_a, mkrow(64'h30, 64'h31));
    chk1("bp_row1_idx", row_a[0], 1'b1);
    chk1("bp_row1_last", last_a, 1'b1);
    chk1("bp_done", done_a, 1'b1);
    step;
    chk1("bp_busy_end", busy_a, 1'b0);
    chk1("bp_done_once", done_a, 1'b0);

    // Ready toggling
    exp_rows[0] = mkrow(64'h40, 64'h41);
    exp_rows[1] = mkrow(64'h50, 64'h51);
    load_a(exp_rows[0], exp_rows[1]);
    or_a = 1'b0;
    ds_a = 1'b1;
    step;
    ds_a = 1'b0;
    pops = 0;
    dones = 0;
    for (int i = 1; i <= 8; i++) begin
      or_a = (i % 2 == 1);
      #1;
      if (ov_a && or_a) begin
        chkn("tog_row_idx", int'(row_a), pops);
        chkw("tog_row_data", od_a, (pops < 2) ? exp_rows[pops] : '1);
        chk1("tog_done_with_pop", done_a, (pops == 1));
        pops++;
      end
      if (done_a) dones++;
      step;
    end
    chkn("tog_pop_count", pops, 2);
    chkn("tog_done_count", dones, 1);
    chk1("tog_busy_end", busy_a, 1'b0);

    // Ignored starts during DRAIN (t+1) and FLUSH (t+3)
    load_a(mkrow(64'h60, 64'h61), mkrow(64'h70, 64'h71));
    or_a = 1'b1;
    ds_a = 1'b1;
    step;
    ds_a = 1'b0;
    en_cnt = 0;
    pops = 0;
    dones = 0;
    for (int i = 1; i <= 8; i++) begin
      ds_a = (i == 1 || i == 3);
      #1;
      if (en_a) en_cnt++;
      if (ov_a && or_a) begin
        chkn("ign_row_idx", int'(row_a), pops);
        pops++;
      end
      if (done_a) dones++;
      step;
    end
    ds_a = 1'b0;
    chkn("ign_en_count", en_cnt, 2);
    chkn("ign_pop_count", pops, 2);
    chkn("ign_done_count", dones, 1);
    chk1("ign_busy_end", busy_a, 1'b0);

    // Reset mid-drain
    load_a(mkrow(64'h80, 64'h81), mkrow(64'h90, 64'h91));
    or_a = 1'b0;
    ds_a = 1'b1;
    step;
    ds_a = 1'b0;
    chk1("mid_first_en", en_a, 1'b1);
    step;
    reset = 1'b1;
    step;
    reset = 1'b0;
    chk1("mid_busy", busy_a, 1'b0);
    chk1("mid_valid", ov_a, 1'b0);
    chk1("mid_en", en_a, 1'b0);
    chkw("mid_data", od_a, '0);
    load_a(mkrow(64'hA0, 64'hA1), mkrow(64'hB0, 64'hB1));
    or_a = 1'b1;
    drain_fast_a("after_rst", mkrow(64'hA0, 64'hA1), mkrow(64'hB0, 64'hB1));

    // DEPTH=1, ml=4: push/pop alternate, done at t+8
    for (int k = 0; k < 4; k++) begin
      exp_rows[k] = mkrow(64'hC000 + 64'(k), 64'hD000 + 64'(k));
      ld_b[k] = exp_rows[k];
    end
    ld_go_b = 1'b1;
    step;
    ld_go_b = 1'b0;
    or_b = 1'b1;
    ds_b = 1'b1;
    step;
    ds_b = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      if (i <= 8) begin
        chk1("d1_en", en_b, (i % 2 == 1));
        if (i % 2 == 0) begin
          chk1("d1_valid", ov_b, 1'b1);
          chkn("d1_row_idx", int'(row_b), i / 2 - 1);
          chkw("d1_row_data", od_b, exp_rows[i/2-1]);
          chk1("d1_last", last_b, (i == 8));
          chk1("d1_done", done_b, (i == 8));
        end else begin
          chk1("d1_valid_gap", ov_b, 1'b0);
        end
      end else begin
        chk1("d1_busy_end", busy_b, 1'b0);
        chk1("d1_done_end", done_b, 1'b0);
        chkw("d1_acc_cleared", acc_b[0] | acc_b[1] | acc_b[2] | acc_b[3], '0);
      end
      step;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/opacc_drain.md
# opacc_drain

Downstream drain stage for the outer-product accumulator (`opacc`). On command it shifts all `ml` rows of the accumulated C matrix out of the accumulator, one row per shift, and feeds zeros back in so the accumulator is cleared. Rows are buffered in a small FIFO and presented on a valid/ready stream toward the vector writeback path. It replaces direct `vo_c` sampling, so downstream backpressure never loses a row.

## Interface

**Parameters**
- `XLEN`, 64: element width in bits.
- `vl`, 2: elements per row.
- `ml`, 2: rows in the accumulator; must be ≥1.
- `DEPTH`, `ml`: FIFO depth in rows; must be ≥1.

**Ports** (clock and reset first)
- `clk` in, 1: clock; all logic rising-edge.
- `reset` in, 1: synchronous, active-high.
- `drain_start` in, 1: single-cycle drain request.
- `busy` out, 1: high whenever the state is not IDLE.
- `done` out, 1: one-cycle pulse when the last row has left the FIFO.
- `en_c` out, 1: shift enable to `opacc` (its `c_valid`).
- `vo_c_acc` out, `vl*XLEN`: data shifted into the accumulator; constant 0.
- `vi_row` in, `vl*XLEN`: accumulator output row (`opacc.vo_c`), valid in the same cycle as `en_c`.
- `out_valid` out, 1: output row valid.
- `out_ready` in, 1: consumer accepts the row.
- `out_data` out, `vl*XLEN`: row data, element j at bits `[j*XLEN +: XLEN]`.
- `out_row` out, `$clog2(ml)` (min 1): row index, 0 = first row shifted out.
- `out_last` out, 1: high with row `ml-1`.

## Operation

**States**
- **IDLE**
  - `drain_start` → DRAIN; clear `shift_cnt`.
  - `drain_start` is ignored in every other state.
- **DRAIN**
  - `en_c = !fifo_full`.
  - When `en_c` is high: push `{vi_row, shift_cnt, shift_cnt==ml-1}` and increment `shift_cnt`.
  - When the push happens with `shift_cnt==ml-1` → FLUSH.
- **FLUSH**
  - `en_c = 0`.
  - When the FIFO becomes empty through a pop → pulse `done` and go to IDLE in the same transition.

**Output stream**
- `out_valid = !fifo_empty`.
- A pop occurs when `out_valid && out_ready`.
- Once `out_valid` is high, `out_data`, `out_row` and `out_last` hold stable until the pop.

**Rules**
- `vo_c_acc` is always 0, so a full drain leaves the accumulator zeroed.
- A push into a full FIFO is impossible by construction.
- A simultaneous push and pop is legal when the FIFO is not full.
- Occupancy never exceeds `DEPTH`; exactly `ml` pushes and `ml` pops occur per drain.
- `shift_cnt` width is `$clog2(ml+1)`.

## Timing

- **Reset values:** state IDLE, FIFO empty, `busy=0`, `done=0`, `en_c=0`, `out_valid=0`. `out_data`, `out_row` and `out_last` are 0.
- **Start latency:** `drain_start` at cycle t → `busy=1` and first `en_c` at t+1 (FIFO empty at start).
- **Capture:** `vi_row` is sampled at the edge that ends each `en_c` cycle. The row appears on `out_*` with `out_valid` one cycle later.
- **Throughput:** with `out_ready` held high, one row per cycle. The last pop happens at t+ml+1 and `done` pulses in that same cycle.
- **Backpressure:** `out_ready=0` fills the FIFO. `en_c` deasserts in the first cycle `fifo_full` is high and reasserts the cycle after a pop.
- **Reset mid-drain:** the FIFO is discarded, state returns to IDLE, and `en_c` drops in the next cycle. The accumulator contents are undefined to the consumer.

## Structure

- **Shared package `opacc_pkg`:**
  - `row_t` (`[vl-1:0][XLEN-1:0]`)
  - drain state enum `{IDLE, DRAIN, FLUSH}`
  - FIFO entry struct `{row_t data; row index; last}`
- **Sub-module `opacc_row_fifo`:**
  - synchronous FIFO, parameter `DEPTH`, generic entry width
  - ports: `push`, `pop`, `full`, `empty`, `wdata`, `rdata`
  - wrap-around pointers plus an occupancy counter
  - first-word-fall-through read
- **FSM and counter** live in `opacc_drain`.

## Test plan

All scenarios use `ml=2`, `vl=2`, `XLEN=64`, with `opacc` and `opacc_drain` connected.

1. **Basic drain.** Accumulator rows `{0,0}` and `{0,1}`; `drain_start` at cycle 5; `out_ready=1`.
   - `en_c` high at cycles 6 and 7.
   - `out` rows `{0,0}` with row 0, then `{0,1}` with row 1 and `out_last=1`.
   - `done` at cycle 8.
   - Accumulator reads all zeros afterward.
2. **Backpressure.** `out_ready=0` for 6 cycles after start.
   - `en_c` pulses exactly twice, then holds 0.
   - `out_data` is stable while stalled.
   - After release, both rows arrive in order and `done` pulses once.
3. **Ready toggling.** `out_ready` alternates 1/0.
   - No row is lost or duplicated.
   - `out_row` sequence is 0, 1.
   - `done` coincides with the pop of row 1.
4. **Ignored start.** A second `drain_start` during DRAIN and during FLUSH.
   - No extra `en_c`.
   - Exactly 2 rows output.
5. **Reset mid-drain.** `reset` after the first `en_c`.
   - Next cycle: `busy=0`, `out_valid=0`, `en_c=0`.
   - A fresh `drain_start` drains 2 rows correctly.
6. **Configuration `DEPTH=1`, `ml=4`, `out_ready=1`.**
   - Rows 0–3 in order.
   - Push and pop in alternate cycles.
   - `out_last` only on row 3.
